// File: rtl/bp_resolve_queue_if.sv
// Bundle of predict-side, execute-side and predictor-update signals for bp_resolve_queue.
// slave is the queue's view; master is the surrounding pipeline's view.
interface bp_resolve_queue_if #(
    parameter int GH_W  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // pdc_valid/pdc_ready: an entry transfers on any cycle where both are high; ex_valid has no back-pressure.
    logic            pdc_valid;
    logic            pdc_ready;
    logic [PC_W-1:0] pdc_pc;
    logic [PC_W-1:0] pdc_target;
    logic            pdc_taken;
    logic            pdc_is_jump;
    logic [GH_W-1:0] pdc_gh;

    logic            ex_valid;
    logic            ex_is_jump;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic            flush;

    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [GH_W-1:0] upd_gh;
    logic            upd_is_jump;
    logic            upd_is_jump_pdc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            upd_mis;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            underflow_err;

    modport slave (
        input  pdc_valid, pdc_pc, pdc_target, pdc_taken, pdc_is_jump, pdc_gh,
        input  ex_valid, ex_is_jump, ex_taken, ex_target, flush,
        output pdc_ready,
        output upd_valid, upd_pc, upd_gh, upd_is_jump, upd_is_jump_pdc, upd_taken,
        output upd_target, upd_mis, redirect_valid, redirect_pc,
        output count, empty, full, underflow_err
    );

    modport master (
        output pdc_valid, pdc_pc, pdc_target, pdc_taken, pdc_is_jump, pdc_gh,
        output ex_valid, ex_is_jump, ex_taken, ex_target, flush,
        input  pdc_ready,
        input  upd_valid, upd_pc, upd_gh, upd_is_jump, upd_is_jump_pdc, upd_taken,
        input  upd_target, upd_mis, redirect_valid, redirect_pc,
        input  count, empty, full, underflow_err
    );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order branch-prediction metadata queue: resolves the head entry against EX outcome,
// emits one-cycle predictor update / front-end redirect pulses and squashes wrong-path entries.
module bp_resolve_queue #(
    parameter int GH_W  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    bp_resolve_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0]     PTR_ONE = 1;
    localparam logic [PC_W-1:0] PC_STEP = 4;

    logic [PC_W-1:0] r_pc_mem    [DEPTH];
    logic [PC_W-1:0] r_tgt_mem   [DEPTH];
    logic            r_taken_mem [DEPTH];
    logic            r_jump_mem  [DEPTH];
    logic [GH_W-1:0] r_gh_mem    [DEPTH];

    logic [AW:0]     r_rp, r_wp;
    logic            r_upd_valid, r_upd_is_jump, r_upd_is_jump_pdc, r_upd_taken, r_upd_mis;
    logic [PC_W-1:0] r_upd_pc, r_upd_target, r_redirect_pc;
    logic [GH_W-1:0] r_upd_gh;
    logic            r_redirect_valid, r_underflow_err;

    logic [CW-1:0]   w_count;
    logic            w_empty, w_full, w_ready, w_push, w_pop, w_mis, w_upd;
    logic [AW-1:0]   w_rd_idx, w_wr_idx;
    logic [PC_W-1:0] w_h_pc, w_h_tgt, w_redirect_pc;
    logic [GH_W-1:0] w_h_gh;
    logic            w_h_taken, w_h_jump;
    logic [AW:0]     w_rp_next;

    assign w_count   = r_wp - r_rp;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == CW'(DEPTH));
    assign w_ready   = !w_full && !bus.flush;
    assign w_push    = bus.pdc_valid && w_ready;
    assign w_pop     = bus.ex_valid && !w_empty && !bus.flush;
    assign w_rd_idx  = r_rp[AW-1:0];
    assign w_wr_idx  = r_wp[AW-1:0];
    assign w_rp_next = r_rp + PTR_ONE;

    assign w_h_pc    = r_pc_mem[w_rd_idx];
    assign w_h_tgt   = r_tgt_mem[w_rd_idx];
    assign w_h_taken = r_taken_mem[w_rd_idx];
    assign w_h_jump  = r_jump_mem[w_rd_idx];
    assign w_h_gh    = r_gh_mem[w_rd_idx];

    // Target only matters when both sides agree the branch is taken.
    assign w_mis = (w_h_jump != bus.ex_is_jump)
                || (bus.ex_is_jump && (w_h_taken != bus.ex_taken))
                || (bus.ex_is_jump && bus.ex_taken && w_h_taken && (w_h_tgt != bus.ex_target));
    assign w_upd = w_h_jump || bus.ex_is_jump;
    assign w_redirect_pc = (bus.ex_taken && bus.ex_is_jump) ? bus.ex_target : w_h_pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[w_wr_idx]    <= bus.pdc_pc;
            r_tgt_mem[w_wr_idx]   <= bus.pdc_target;
            r_taken_mem[w_wr_idx] <= bus.pdc_taken;
            r_jump_mem[w_wr_idx]  <= bus.pdc_is_jump;
            r_gh_mem[w_wr_idx]    <= bus.pdc_gh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rp              <= '0;
            r_wp              <= '0;
            r_upd_valid       <= 1'b0;
            r_upd_pc          <= '0;
            r_upd_gh          <= '0;
            r_upd_is_jump     <= 1'b0;
            r_upd_is_jump_pdc <= 1'b0;
            r_upd_taken       <= 1'b0;
            r_upd_target      <= '0;
            r_upd_mis         <= 1'b0;
            r_redirect_valid  <= 1'b0;
            r_redirect_pc     <= '0;
            r_underflow_err   <= 1'b0;
        end else begin
            r_upd_valid      <= 1'b0;
            r_redirect_valid <= 1'b0;
            if (bus.ex_valid && w_empty) r_underflow_err <= 1'b1;
            if (bus.flush) begin
                r_rp <= '0;
                r_wp <= '0;
            end else begin
                if (w_pop) begin
                    r_rp             <= w_rp_next;
                    r_upd_valid      <= w_upd;
                    r_redirect_valid <= w_mis;
                    if (w_upd) begin
                        r_upd_pc          <= w_h_pc;
                        r_upd_gh          <= w_h_gh;
                        r_upd_is_jump     <= bus.ex_is_jump;
                        r_upd_is_jump_pdc <= w_h_jump;
                        r_upd_taken       <= bus.ex_taken;
                        r_upd_target      <= bus.ex_target;
                        r_upd_mis         <= w_mis;
                    end
                    if (w_mis) r_redirect_pc <= w_redirect_pc;
                end
                // A mispredict squashes every younger entry, including a same-cycle push.
                if (w_pop && w_mis) r_wp <= w_rp_next;
                else if (w_push)    r_wp <= r_wp + PTR_ONE;
            end
        end
    end

    assign bus.pdc_ready       = w_ready;
    assign bus.count           = w_count;
    assign bus.empty           = w_empty;
    assign bus.full            = w_full;
    assign bus.underflow_err   = r_underflow_err;
    assign bus.upd_valid       = r_upd_valid;
    assign bus.upd_pc          = r_upd_pc;
    assign bus.upd_gh          = r_upd_gh;
    assign bus.upd_is_jump     = r_upd_is_jump;
    assign bus.upd_is_jump_pdc = r_upd_is_jump_pdc;
    assign bus.upd_taken       = r_upd_taken;
    assign bus.upd_target      = r_upd_target;
    assign bus.upd_mis         = r_upd_mis;
    assign bus.redirect_valid  = r_redirect_valid;
    assign bus.redirect_pc     = r_redirect_pc;
endmodule
